// File: rtl/grn_floyd_ctrl_pkg.sv
// Shared definitions for the GRN Floyd cycle-detection controller.
//   - Default network width and counter width.
//   - Controller state encoding.
//   - Helper that marks which states report the controller as busy.
package grn_floyd_ctrl_pkg;

  localparam int unsigned DefNumNodes = 16;
  localparam int unsigned DefCntW     = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRunA,
    StRunB,
    StRunCmp,
    StPerStep,
    StPerCmp,
    StFin
  } grn_state_e;

  // Busy covers everything from node reload up to, but not including, the done cycle.
  function automatic logic is_busy_state(grn_state_e st);
    return (st != StIdle) && (st != StFin);
  endfunction

endpackage

// File: rtl/grn_vec_cmp.sv
// Combinational equality comparator for the gathered tortoise/hare state vectors.
// Ports:
//   a, b   : WIDTH-bit state vectors (bit i = node i)
//   equal  : 1 when a and b are identical
module grn_vec_cmp
  import grn_floyd_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefNumNodes
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             equal
);

  assign equal = (a == b);

endmodule

// File: rtl/grn_floyd_ctrl.sv
// Floyd cycle-detection controller sitting upstream of the GRN node array.
// Loads an initial state into the nodes, steps the tortoise (s0) once per two hare (s1)
// steps until the two copies meet, then steps the hare alone to measure the attractor period.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start, init_vec      : launch request and initial network state (accepted in idle only)
//   s0_vec, s1_vec       : gathered tortoise / hare states from the nodes
//   reset_nos            : node reload strobe; init_state is the per-node reload value
//   start_s0, start_s1   : tortoise / hare step strobes
//   busy, done           : in-progress flag and one-cycle completion pulse
//   timeout              : iteration limit reached (valid from done until next start)
//   meet_iter, period    : Floyd meeting iteration and attractor cycle length
module grn_floyd_ctrl
  import grn_floyd_ctrl_pkg::*;
#(
  parameter int unsigned      NUM_NODES = DefNumNodes,
  parameter int unsigned      CNT_W     = DefCntW,
  parameter logic [CNT_W-1:0] MAX_ITER  = CNT_W'(16'hFFFF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_NODES-1:0] init_vec,
  input  logic [NUM_NODES-1:0] s0_vec,
  input  logic [NUM_NODES-1:0] s1_vec,
  output logic                 reset_nos,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     meet_iter,
  output logic [CNT_W-1:0]     period
);

  grn_state_e state_q, state_d;

  logic [NUM_NODES-1:0] init_state_q, init_state_d;
  logic [CNT_W-1:0]     meet_q, meet_d, meet_inc;
  logic [CNT_W-1:0]     period_q, period_d, period_inc;
  logic                 timeout_q, timeout_d;

  logic reset_nos_q, start_s0_q, start_s1_q, busy_q, done_q;
  logic reset_nos_d, start_s0_d, start_s1_d, busy_d, done_d;

  logic vec_eq;

  grn_vec_cmp #(
    .WIDTH(NUM_NODES)
  ) u_cmp (
    .a     (s0_vec),
    .b     (s1_vec),
    .equal (vec_eq)
  );

  // Saturating increments; counters never wrap past the limit.
  assign meet_inc   = (meet_q == MAX_ITER) ? meet_q : meet_q + CNT_W'(1);
  assign period_inc = (period_q == MAX_ITER) ? period_q : period_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    init_state_d = init_state_q;
    meet_d       = meet_q;
    period_d     = period_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          init_state_d = init_vec;
          meet_d       = '0;
          period_d     = '0;
          timeout_d    = 1'b0;
          state_d      = StLoad;
        end
      end
      StLoad:  state_d = StRunA;
      StRunA:  state_d = StRunB;
      StRunB:  state_d = StRunCmp;
      StRunCmp: begin
        // s0_vec holds x_k and s1_vec holds x_2k here.
        meet_d = meet_inc;
        if (vec_eq) begin
          state_d = StPerStep;
        end else if (meet_inc == MAX_ITER) begin
          timeout_d = 1'b1;
          state_d   = StFin;
        end else begin
          state_d = StRunA;
        end
      end
      StPerStep: state_d = StPerCmp;
      StPerCmp: begin
        period_d = period_inc;
        if (vec_eq) begin
          state_d = StFin;
        end else if (period_inc == MAX_ITER) begin
          timeout_d = 1'b1;
          state_d   = StFin;
        end else begin
          state_d = StPerStep;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Strobes are decoded from the next state and registered, so each one is high
    // for exactly the cycle the FSM spends in the matching state.
    reset_nos_d = (state_d == StLoad);
    start_s0_d  = (state_d == StRunA) || (state_d == StRunB);
    start_s1_d  = start_s0_d || (state_d == StPerStep);
    busy_d      = is_busy_state(state_d);
    done_d      = (state_d == StFin);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      init_state_q <= '0;
      meet_q       <= '0;
      period_q     <= '0;
      timeout_q    <= 1'b0;
      reset_nos_q  <= 1'b0;
      start_s0_q   <= 1'b0;
      start_s1_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_state_q <= init_state_d;
      meet_q       <= meet_d;
      period_q     <= period_d;
      timeout_q    <= timeout_d;
      reset_nos_q  <= reset_nos_d;
      start_s0_q   <= start_s0_d;
      start_s1_q   <= start_s1_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign reset_nos  = reset_nos_q;
  assign init_state = init_state_q;
  assign start_s0   = start_s0_q;
  assign start_s1   = start_s1_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign meet_iter  = meet_q;
  assign period     = period_q;

endmodule

// File: tb/tb_grn_floyd_ctrl.sv
// Self-checking bench for grn_floyd_ctrl. Two controllers (default limit, limit 3) each
// drive a behavioural 4-node network: s1 steps on every hare strobe, s0 on every second
// tortoise strobe (pass flag set by reload). Expected results go to a scoreboard queue
// at launch and are popped when done appears.
module tb_grn_floyd_ctrl;

  localparam int unsigned NN = 4;
  localparam int unsigned CW = 16;

  typedef struct {
    logic [CW-1:0] meet;
    logic [CW-1:0] per;
    logic          to;
    logic [NN-1:0] init;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_a = 1'b0;
  logic          start_b = 1'b0;
  logic [NN-1:0] init_vec = '0;
  int            net_sel = 0;

  logic [NN-1:0] s0_a, s1_a, init_state_a;
  logic [NN-1:0] s0_b, s1_b, init_state_b;
  logic          pass_a, pass_b;
  logic          reset_nos_a, start_s0_a, start_s1_a, busy_a, done_a, timeout_a;
  logic          reset_nos_b, start_s0_b, start_s1_b, busy_b, done_b, timeout_b;
  logic [CW-1:0] meet_a, period_a, meet_b, period_b;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_s0_a = 0;
  int   n_s1_a = 0;

  always #5 clk = ~clk;

  grn_floyd_ctrl #(
    .NUM_NODES (NN),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start_a),
    .init_vec   (init_vec),
    .s0_vec     (s0_a),
    .s1_vec     (s1_a),
    .reset_nos  (reset_nos_a),
    .init_state (init_state_a),
    .start_s0   (start_s0_a),
    .start_s1   (start_s1_a),
    .busy       (busy_a),
    .done       (done_a),
    .timeout    (timeout_a),
    .meet_iter  (meet_a),
    .period     (period_a)
  );

  grn_floyd_ctrl #(
    .NUM_NODES (NN),
    .CNT_W     (CW),
    .MAX_ITER  (16'd3)
  ) dut_lim (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .init_vec   (init_vec),
    .s0_vec     (s0_b),
    .s1_vec     (s1_b),
    .reset_nos  (reset_nos_b),
    .init_state (init_state_b),
    .start_s0   (start_s0_b),
    .start_s1   (start_s1_b),
    .busy       (busy_b),
    .done       (done_b),
    .timeout    (timeout_b),
    .meet_iter  (meet_b),
    .period     (period_b)
  );

  // 0: identity, 1: 4-node rotate-left ring, 2: 3-node net converging to 111,
  // 3: counter 0..6 with a 4->5->6 attractor.
  function automatic logic [NN-1:0] net_f(input int sel, input logic [NN-1:0] s);
    case (sel)
      0:       return s;
      1:       return {s[NN-2:0], s[NN-1]};
      2:       return {1'b0, s[2:0] | {s[1:0], 1'b1}};
      default: return (s < 4'd6) ? s + 4'd1 : 4'd4;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset_nos_a) begin
      s0_a <= init_state_a; s1_a <= init_state_a; pass_a <= 1'b1;
    end else begin
      if (start_s1_a) s1_a <= net_f(net_sel, s1_a);
      if (start_s0_a) begin
        if (pass_a) s0_a <= net_f(net_sel, s0_a);
        pass_a <= ~pass_a;
      end
    end
    if (reset_nos_b) begin
      s0_b <= init_state_b; s1_b <= init_state_b; pass_b <= 1'b1;
    end else begin
      if (start_s1_b) s1_b <= net_f(net_sel, s1_b);
      if (start_s0_b) begin
        if (pass_b) s0_b <= net_f(net_sel, s0_b);
        pass_b <= ~pass_b;
      end
    end
  end

  always @(posedge clk) begin
    if (start_s0_a) n_s0_a <= n_s0_a + 1;
    if (start_s1_a) n_s1_a <= n_s1_a + 1;
  end

  function automatic exp_t mk_exp(input int m, input int p, input logic to,
                                  input logic [NN-1:0] init, input int lat);
    exp_t e;
    e.meet = CW'(m); e.per = CW'(p); e.to = to; e.init = init; e.lat = lat;
    return e;
  endfunction

  // Golden Floyd model on the abstract sequence x_{n+1} = f(x_n).
  function automatic exp_t floyd_model(input int sel, input logic [NN-1:0] x0, input int lim);
    logic [NN-1:0] t, h;
    int k, p;
    logic to;
    t = x0; h = x0; k = 0; p = 0; to = 1'b0;
    for (int i = 0; i < lim; i++) begin
      t = net_f(sel, t);
      h = net_f(sel, net_f(sel, h));
      k++;
      if (t == h) break;
    end
    if (t != h) begin
      to = 1'b1;
    end else begin
      for (int i = 0; i < lim; i++) begin
        h = net_f(sel, h);
        p++;
        if (h == t) break;
      end
      if (h != t) to = 1'b1;
    end
    return mk_exp(k, p, to, x0, 3 + 3 * k + 2 * p);
  endfunction

  // Launches one job on controller A (which=0) or B (which=1); cycle 1 is the accept cycle.
  task automatic run_job(input bit which, input int sel, input logic [NN-1:0] init,
                         input bit spam, output int cyc, output int busy_cyc, output bit got);
    @(negedge clk);
    net_sel  = sel;
    init_vec = init;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    cyc = 1; busy_cyc = 0; got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      cyc++;
      start_a = 1'b0;
      start_b = 1'b0;
      if (spam) begin
        start_a  = cyc[0];
        init_vec = NN'($urandom);
      end
      if (which ? busy_b : busy_a) busy_cyc++;
      if (which ? done_b : done_a) got = 1'b1;
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    start_a = 1'b1; start_b = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; rst = 1'b0;
    checks++;
    if ({reset_nos_a, start_s0_a, start_s1_a, busy_a, done_a, timeout_a} !== 6'b0) begin
      errors++;
      $display("FAIL reset ctrl_a: got %b want 000000",
               {reset_nos_a, start_s0_a, start_s1_a, busy_a, done_a, timeout_a});
    end
    checks++;
    if ({meet_a, period_a} !== '0) begin
      errors++; $display("FAIL reset counters_a: got %0d/%0d want 0/0", meet_a, period_a);
    end
    checks++;
    if (init_state_a !== '0) begin
      errors++; $display("FAIL reset init_state_a: got %b want 0000", init_state_a);
    end
    checks++;
    if ({reset_nos_b, start_s0_b, start_s1_b, busy_b, done_b, timeout_b, meet_b} !== '0) begin
      errors++; $display("FAIL reset outputs_b: got nonzero want 0");
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++; $display("FAIL reset start_ignored: busy got %b%b want 00", busy_a, busy_b);
    end
  endtask

  task automatic test_networks();
    exp_t e, o;
    int sel, cyc, bc, b0, b1;
    bit got;
    logic [NN-1:0] init;
    for (int n = 0; n < 6; n++) begin
      case (n)
        0: begin sel = 0; init = 4'b1010; e = mk_exp(1, 1, 1'b0, init, 8);  end
        1: begin sel = 1; init = 4'b0001; e = mk_exp(4, 4, 1'b0, init, 23); end
        2: begin sel = 2; init = 4'b0011; e = mk_exp(1, 1, 1'b0, init, 8);  end
        3: begin sel = 3; init = 4'b0000; e = mk_exp(6, 3, 1'b0, init, 27); end
        4: begin sel = 1; init = NN'($urandom_range(1, 15)); e = floyd_model(sel, init, 65535); end
        default: begin
          sel = 3; init = NN'($urandom_range(0, 15)); e = floyd_model(sel, init, 65535);
        end
      endcase
      sb_q.push_back(e);
      b0 = n_s0_a; b1 = n_s1_a;
      run_job(1'b0, sel, init, 1'b0, cyc, bc, got);
      o = sb_q.pop_front();
      checks++;
      if (!got) begin errors++; $display("FAIL net%0d done: not seen within bound", n); end
      checks++;
      if (cyc !== o.lat) begin errors++; $display("FAIL net%0d latency: got %0d want %0d", n, cyc, o.lat); end
      checks++;
      if (bc !== o.lat - 2) begin errors++; $display("FAIL net%0d busy_cycles: got %0d want %0d", n, bc, o.lat - 2); end
      checks++;
      if (meet_a !== o.meet) begin errors++; $display("FAIL net%0d meet_iter: got %0d want %0d", n, meet_a, o.meet); end
      checks++;
      if (period_a !== o.per) begin errors++; $display("FAIL net%0d period: got %0d want %0d", n, period_a, o.per); end
      checks++;
      if (timeout_a !== o.to) begin errors++; $display("FAIL net%0d timeout: got %b want %b", n, timeout_a, o.to); end
      checks++;
      if (init_state_a !== o.init) begin errors++; $display("FAIL net%0d init_state: got %b want %b", n, init_state_a, o.init); end
      checks++;
      if (n_s0_a - b0 !== 2 * int'(o.meet)) begin
        errors++; $display("FAIL net%0d s0_strobes: got %0d want %0d", n, n_s0_a - b0, 2 * int'(o.meet));
      end
      checks++;
      if (n_s1_a - b1 !== 2 * int'(o.meet) + int'(o.per)) begin
        errors++;
        $display("FAIL net%0d s1_strobes: got %0d want %0d", n, n_s1_a - b1, 2 * int'(o.meet) + int'(o.per));
      end
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || meet_a !== o.meet || period_a !== o.per) begin
        errors++;
        $display("FAIL net%0d hold: done=%b meet=%0d period=%0d want 0/%0d/%0d", n, done_a, meet_a, period_a, o.meet, o.per);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t o;
    int cyc, bc;
    bit got;
    sb_q.push_back(mk_exp(3, 0, 1'b1, 4'b0001, 12));
    run_job(1'b1, 1, 4'b0001, 1'b0, cyc, bc, got);
    o = sb_q.pop_front();
    checks++;
    if (!got || cyc !== o.lat) begin errors++; $display("FAIL to latency: got %0d (seen=%b) want %0d", cyc, got, o.lat); end
    checks++;
    if (bc !== 10) begin errors++; $display("FAIL to busy_cycles: got %0d want 10", bc); end
    checks++;
    if (timeout_b !== o.to) begin errors++; $display("FAIL to timeout: got %b want 1", timeout_b); end
    checks++;
    if (meet_b !== o.meet || period_b !== o.per) begin
      errors++; $display("FAIL to counters: got %0d/%0d want 3/0", meet_b, period_b);
    end
    // A converging job on the limited controller must clear the stale timeout.
    sb_q.push_back(mk_exp(1, 1, 1'b0, 4'b0110, 8));
    run_job(1'b1, 0, 4'b0110, 1'b0, cyc, bc, got);
    o = sb_q.pop_front();
    checks++;
    if (!got || cyc !== o.lat) begin errors++; $display("FAIL to2 latency: got %0d want %0d", cyc, o.lat); end
    checks++;
    if (timeout_b !== o.to || meet_b !== o.meet || period_b !== o.per) begin
      errors++; $display("FAIL to2 result: got %b/%0d/%0d want 0/1/1", timeout_b, meet_b, period_b);
    end
  endtask

  task automatic test_start_ignored();
    exp_t o;
    int cyc, bc, extra;
    bit got;
    sb_q.push_back(mk_exp(4, 4, 1'b0, 4'b0001, 23));
    run_job(1'b0, 1, 4'b0001, 1'b1, cyc, bc, got);
    o = sb_q.pop_front();
    checks++;
    if (!got || cyc !== o.lat) begin errors++; $display("FAIL spam latency: got %0d want %0d", cyc, o.lat); end
    checks++;
    if (init_state_a !== o.init) begin errors++; $display("FAIL spam init_state: got %b want %b", init_state_a, o.init); end
    checks++;
    if (meet_a !== o.meet || period_a !== o.per) begin
      errors++; $display("FAIL spam counters: got %0d/%0d want 4/4", meet_a, period_a);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_a || busy_a) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL spam after_done: got %0d busy/done cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    int sel, cyc, bc;
    bit got;
    logic [NN-1:0] init;
    for (int n = 0; n < 3; n++) begin
      case (n)
        0: begin sel = 1; init = 4'b1000; e = mk_exp(4, 4, 1'b0, init, 23); end
        1: begin sel = 0; init = 4'b0110; e = mk_exp(1, 1, 1'b0, init, 8);  end
        default: begin sel = 2; init = 4'b0100; e = mk_exp(2, 1, 1'b0, init, 11); end
      endcase
      sb_q.push_back(e);
      run_job(1'b0, sel, init, 1'b0, cyc, bc, got);
      o = sb_q.pop_front();
      checks++;
      if (!got || cyc !== o.lat) begin errors++; $display("FAIL b2b%0d latency: got %0d want %0d", n, cyc, o.lat); end
      checks++;
      if (meet_a !== o.meet || period_a !== o.per || timeout_a !== o.to) begin
        errors++;
        $display("FAIL b2b%0d result: got %0d/%0d/%b want %0d/%0d/%b", n, meet_a, period_a, timeout_a, o.meet, o.per, o.to);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t o;
    int cyc, bc, n1, act;
    bit got;
    @(negedge clk);
    net_sel = 1; init_vec = 4'b0001; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (meet_a !== 16'd2 || busy_a !== 1'b1) begin
      errors++; $display("FAIL rmid before: meet=%0d busy=%b want 2/1", meet_a, busy_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({reset_nos_a, start_s0_a, start_s1_a, busy_a, done_a, timeout_a, meet_a, period_a,
         init_state_a} !== '0) begin
      errors++; $display("FAIL rmid outputs: got nonzero want all 0");
    end
    n1 = n_s1_a; act = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy_a || done_a || reset_nos_a) act++;
    end
    checks++;
    if (act !== 0 || n_s1_a !== n1) begin
      errors++; $display("FAIL rmid idle: got %0d active cycles, %0d strobes want 0", act, n_s1_a - n1);
    end
    sb_q.push_back(mk_exp(4, 4, 1'b0, 4'b0001, 23));
    run_job(1'b0, 1, 4'b0001, 1'b0, cyc, bc, got);
    o = sb_q.pop_front();
    checks++;
    if (!got || cyc !== o.lat) begin errors++; $display("FAIL rmid fresh latency: got %0d want %0d", cyc, o.lat); end
    checks++;
    if (meet_a !== o.meet || period_a !== o.per || timeout_a !== o.to) begin
      errors++; $display("FAIL rmid fresh result: got %0d/%0d/%b want 4/4/0", meet_a, period_a, timeout_a);
    end
  endtask

  initial begin
    test_reset();
    test_networks();
    test_timeout();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/grn_floyd_ctrl.md
Name: grn_floyd_ctrl

Overview:
Controller that sits directly upstream of the GRN node array. It loads an initial state into the nodes and then steps them: the tortoise copy (s0) advances one step for every two hare (s1) steps. It compares the gathered s0/s1 state vectors to detect an attractor using Floyd cycle detection. It then measures the attractor period and reports the result to the host side.

Parameters:
NUM_NODES, 16, number of network nodes; width of all state vectors
CNT_W, 16, width of iteration and period counters
MAX_ITER, 16'hFFFF, iteration limit for each phase before timeout is declared

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  launch request; sampled only in IDLE
init_vec  in  NUM_NODES  initial network state; captured when start is accepted
s0_vec  in  NUM_NODES  concatenated tortoise states from the nodes (bit i = node i)
s1_vec  in  NUM_NODES  concatenated hare states from the nodes
reset_nos  out  1  node reload strobe
init_state  out  NUM_NODES  per-node reload value (bit i goes to node i)
start_s0  out  1  tortoise step strobe (nodes advance s0 on every second strobe)
start_s1  out  1  hare step strobe (nodes advance s1 on every strobe)
busy  out  1  high from start acceptance until the cycle done is asserted
done  out  1  one-cycle completion pulse
timeout  out  1  result flag: limit reached; valid from done until the next start
meet_iter  out  CNT_W  Floyd meeting iteration k (x_k == x_2k)
period  out  CNT_W  attractor cycle length

Behaviour:
- Reset: state=IDLE. All outputs are 0: reset_nos, start_s0, start_s1, busy, done, timeout, meet_iter, period, init_state. Reset mid-operation aborts immediately; the node array is not touched until the next start.
- All strobes are registered outputs, decoded from the current state.
- IDLE: on start=1, capture init_vec into init_state; clear meet_iter, period and timeout; set busy=1; go to LOAD. start is ignored in every other state.
- LOAD (1 cycle): reset_nos=1 → RUN_A.
- After LOAD the node pass flags are 1, so the first start_s0 strobe updates s0.
- RUN_A (1 cycle): start_s0=start_s1=1 → RUN_B.
- RUN_B (1 cycle): start_s0=start_s1=1 → RUN_CMP.
- RUN_CMP (1 cycle): no strobes; meet_iter increments; s0_vec now holds x_k and s1_vec holds x_2k.
  - If s0_vec==s1_vec → PER_STEP.
  - Else if the incremented meet_iter equals MAX_ITER → timeout=1 → FIN.
  - Else → RUN_A.
  - Each Floyd iteration is 3 cycles.
- PER_STEP (1 cycle): start_s1=1 only. s0 is frozen; the pass flag stays 1 because every phase-1 iteration issued an even number of strobes. → PER_CMP.
- PER_CMP (1 cycle): period increments.
  - If s1_vec==s0_vec → FIN.
  - Else if period==MAX_ITER → timeout=1 → FIN.
  - Else → PER_STEP.
- FIN (1 cycle): done=1, busy=0 → IDLE. meet_iter, period, timeout and init_state hold until the next accepted start.
- Counters saturate at MAX_ITER and never wrap.
- On timeout in phase 1, period=0.
- Fixed-point start state: first compare matches → meet_iter=1, period=1.
- Latency, accept-to-done: 1 (accept) + 1 (LOAD) + 3·meet_iter + 2·period + 1 (FIN) cycles.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared grn package holds:
  - state enum: IDLE, LOAD, RUN_A, RUN_B, RUN_CMP, PER_STEP, PER_CMP, FIN
  - default NUM_NODES and CNT_W constants
- One natural sub-module: grn_vec_cmp, a registered-free NUM_NODES-wide equality comparator shared by both compare states.
- Counters and FSM remain in the top level.

Test Plan:
- Identity network (s_next=s), NUM_NODES=4, init 4'b1010 → done after 1+1+3+2+1=8 cycles; meet_iter=1, period=1, timeout=0.
- 4-node rotate-left ring, init 4'b0001 → meet_iter=4, period=4, timeout=0; start_s1 strobes total 8+4=12; start_s0 strobes total 8.
- Same ring, MAX_ITER=3 → timeout=1 with done after 3 iterations; meet_iter=3, period=0.
- start pulsed repeatedly while busy → ignored; single done pulse; init_state unchanged from the first capture.
- rst asserted in the cycle after the 2nd RUN_CMP → next cycle all outputs 0 and state IDLE; a fresh start then completes normally with correct results.
- 3-node ring with transient: init 3'b011 on a network converging to 3'b111 → meet_iter=1 or the first k where x_k==x_2k; period=1. The bench checks against a golden Floyd model.
